// File: rtl/buf_fifo_sync.sv
// Synchronous FIFO with occupancy count, programmable almost-full, flush and sticky error flags.
// Define BUF_FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout/r_ack are registered.
module buf_fifo_sync #(
  parameter int BUF_ID   = 0,
  parameter int ADDR_L   = 5,
  parameter int DATA_L   = 16,
  parameter int AFULL_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              we,
  input  logic [DATA_L-1:0] din,
  input  logic              re,
  output logic [DATA_L-1:0] dout,
  output logic              w_ack,
  output logic              r_ack,
  output logic [ADDR_L:0]   count,
  output logic              full,
  output logic              avail,
  output logic              almost_full,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int              DEPTH   = 1 << ADDR_L;
  localparam logic [ADDR_L:0] C_DEPTH = (ADDR_L+1)'(DEPTH);
  localparam logic [ADDR_L:0] C_AFTH  = (ADDR_L+1)'(AFULL_TH);

  logic [DATA_L-1:0] r_mem [DEPTH];
  logic [ADDR_L-1:0] r_wpt;
  logic [ADDR_L-1:0] r_rpt;
  logic [ADDR_L:0]   r_count;
  logic              r_w_ack_p1;
  logic              r_ovf;
  logic              r_udf;

  logic              w_full;
  logic              w_avail;
  logic              w_re_acc;
  logic              w_we_acc;
  logic [ADDR_L:0]   w_free;

  assign w_full   = (r_count == C_DEPTH);
  assign w_avail  = (r_count != '0);
  assign w_free   = C_DEPTH - r_count;
  assign w_re_acc = re && w_avail;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign w_we_acc = we && (!w_full || w_re_acc);

  assign count       = r_count;
  assign full        = w_full;
  assign avail       = w_avail;
  assign almost_full = (w_free <= C_AFTH);
  assign w_ack       = r_w_ack_p1;
  assign ovf_err     = r_ovf;
  assign udf_err     = r_udf;

  // Storage: contents survive flush and reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_we_acc && !flush)
      r_mem[r_wpt] <= din;
  end

  // Control stage: pointers, occupancy, acks and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wpt      <= '0;
      r_rpt      <= '0;
      r_count    <= '0;
      r_w_ack_p1 <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else if (flush) begin
      r_wpt      <= '0;
      r_rpt      <= '0;
      r_count    <= '0;
      r_w_ack_p1 <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_w_ack_p1 <= w_we_acc;
      if (w_we_acc)
        r_wpt <= r_wpt + 1'b1;
      if (w_re_acc)
        r_rpt <= r_rpt + 1'b1;
      case ({w_we_acc, w_re_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (we && !w_we_acc)
        r_ovf <= 1'b1;
      if (re && !w_avail)
        r_udf <= 1'b1;
    end
  end

`ifdef BUF_FIFO_FWFT_EN
  assign dout  = w_avail ? r_mem[r_rpt] : '0;
  assign r_ack = w_re_acc;
`else
  logic [DATA_L-1:0] r_dout_p1;
  logic              r_r_ack_p1;

  // Read stage: registered head word, held when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_p1  <= '0;
      r_r_ack_p1 <= 1'b0;
    end else if (flush) begin
      r_dout_p1  <= '0;
      r_r_ack_p1 <= 1'b0;
    end else begin
      r_r_ack_p1 <= w_re_acc;
      if (w_re_acc)
        r_dout_p1 <= r_mem[r_rpt];
    end
  end

  assign dout  = r_dout_p1;
  assign r_ack = r_r_ack_p1;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !flush) begin
      if (we && w_full && !re)
        $display("BUF:ID:%0d ERROR FULL", BUF_ID);
      if (re && !w_avail)
        $display("BUF:ID:%0d ERROR EMPTY", BUF_ID);
    end
  end
`endif

endmodule

// File: tb/tb_buf_fifo_sync.sv
// Directed bench for buf_fifo_sync (ADDR_L=2, AFULL_TH=1) with immediate-assertion checks.
module tb_buf_fifo_sync;

  localparam int ADDR_L = 2;
  localparam int DATA_L = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              we;
  logic [DATA_L-1:0] din;
  logic              re;
  logic [DATA_L-1:0] dout;
  logic              w_ack;
  logic              r_ack;
  logic [ADDR_L:0]   count;
  logic              full;
  logic              avail;
  logic              almost_full;
  logic              ovf_err;
  logic              udf_err;

  int n_run  = 0;
  int n_fail = 0;

  buf_fifo_sync #(.BUF_ID(0), .ADDR_L(ADDR_L), .DATA_L(DATA_L), .AFULL_TH(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .we(we), .din(din), .re(re),
    .dout(dout), .w_ack(w_ack), .r_ack(r_ack), .count(count), .full(full),
    .avail(avail), .almost_full(almost_full), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_head;
    rst = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    step();
    step();
    chk("rst_dout", dout, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_avail", avail, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_wack", w_ack, 0);
    chk("rst_rack", r_ack, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_udf", udf_err, 0);
    rst = 1'b0;
    step();

`ifdef BUF_FIFO_FWFT_EN
    we = 1'b1; din = 16'h0077;
    step();
    we = 1'b0;
    chk("fwft_dout", dout, 16'h0077);
    chk("fwft_avail", avail, 1);
    chk("fwft_rack_idle", r_ack, 0);
    re = 1'b1;
    #1;
    chk("fwft_rack_same", r_ack, 1);
    step();
    re = 1'b0;
    chk("fwft_empty_dout", dout, 0);
    chk("fwft_empty_avail", avail, 0);
    chk("fwft_count", count, 0);
`else
    // Fill to full
    we = 1'b1; din = 16'h0011;
    step();
    chk("w1_count", count, 1);
    chk("w1_wack", w_ack, 1);
    chk("w1_rack", r_ack, 0);
    din = 16'h0022;
    step();
    chk("w2_count", count, 2);
    chk("w2_afull", almost_full, 0);
    chk("w2_wack", w_ack, 1);
    din = 16'h0033;
    step();
    chk("w3_count", count, 3);
    chk("w3_afull", almost_full, 1);
    chk("w3_full", full, 0);
    chk("w3_wack", w_ack, 1);
    din = 16'h0044;
    step();
    chk("w4_count", count, 4);
    chk("w4_full", full, 1);
    chk("w4_wack", w_ack, 1);

    // Overflow attempt
    din = 16'h0055;
    step();
    we = 1'b0;
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_count", count, 4);
    chk("ovf_wack", w_ack, 0);

    // Drain in order
    re = 1'b1;
    step();
    chk("r1_dout", dout, 16'h0011);
    chk("r1_rack", r_ack, 1);
    chk("r1_count", count, 3);
    step();
    chk("r2_dout", dout, 16'h0022);
    chk("r2_rack", r_ack, 1);
    step();
    chk("r3_dout", dout, 16'h0033);
    chk("r3_rack", r_ack, 1);
    step();
    chk("r4_dout", dout, 16'h0044);
    chk("r4_rack", r_ack, 1);
    chk("r4_avail", avail, 0);
    chk("r4_count", count, 0);

    // Underflow
    step();
    re = 1'b0;
    chk("udf_flag", udf_err, 1);
    chk("udf_rack", r_ack, 0);
    chk("udf_dout", dout, 16'h0044);

    // Read+write on empty: read rejected, write kept
    re = 1'b1; we = 1'b1; din = 16'h00AA;
    step();
    we = 1'b0;
    chk("rwe_count", count, 1);
    chk("rwe_udf", udf_err, 1);
    chk("rwe_rack", r_ack, 0);
    chk("rwe_wack", w_ack, 1);
    step();
    re = 1'b0;
    chk("rwe_dout", dout, 16'h00AA);
    chk("rwe_rack2", r_ack, 1);
    chk("rwe_count2", count, 0);

    // Flush clears errors and dout
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ovf", ovf_err, 0);
    chk("fl_udf", udf_err, 0);
    chk("fl_dout", dout, 0);
    chk("fl_count", count, 0);

    // Refill, then simultaneous read/write on full across pointer wrap
    we = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din = 16'(i);
      q.push_back(16'(i));
      step();
    end
    chk("wrap_full", full, 1);
    re = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = 16'h0060 + 16'(i);
      exp_head = q.pop_front();
      q.push_back(din);
      step();
      chk("wrap_dout", dout, exp_head);
      chk("wrap_count", count, 4);
      chk("wrap_ovf", ovf_err, 0);
      chk("wrap_rack", r_ack, 1);
      chk("wrap_wack", w_ack, 1);
    end
    re = 1'b0;

    // Overflow, drop to 3, then flush with concurrent write
    din = 16'h0077;
    step();
    we = 1'b0;
    chk("ovf2_flag", ovf_err, 1);
    re = 1'b1;
    step();
    re = 1'b0;
    chk("ovf2_count", count, 3);
    chk("ovf2_dout", dout, 16'h0068);
    flush = 1'b1; we = 1'b1; din = 16'h0099;
    step();
    flush = 1'b0; we = 1'b0;
    chk("flw_count", count, 0);
    chk("flw_ovf", ovf_err, 0);
    chk("flw_wack", w_ack, 0);
    chk("flw_avail", avail, 0);

    // Asynchronous reset mid-burst
    we = 1'b1; din = 16'h0101;
    step();
    din = 16'h0102;
    step();
    chk("burst_count", count, 2);
    re = 1'b1;
    step();
    chk("burst_rack", r_ack, 1);
    chk("burst_dout", dout, 16'h0101);
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    chk("arst_wack", w_ack, 0);
    chk("arst_rack", r_ack, 0);
    chk("arst_avail", avail, 0);
    we = 1'b0; re = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", count, 0);
    chk("post_rst_udf", udf_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/buf_fifo_sync.md
# buf_fifo_sync

Parametrised synchronous FIFO that replaces the edge-triggered strobe buffer used between pipeline stages and the memory/IO queues. All state changes on `posedge clk`, with single-cycle strobe requests and full/empty detection. It also provides:
- full 2^ADDR_L depth,
- occupancy count and programmable almost-full,
- synchronous flush,
- sticky overflow/underflow error flags.

## Interface
- `BUF_ID`, 0, instance tag printed in simulation error messages.
- `ADDR_L`, 5, pointer width; depth = 2^ADDR_L entries, all usable.
- `DATA_L`, 16, data width.
- `AFULL_TH`, 2, `almost_full` asserts when free entries <= AFULL_TH; legal range 0..2^ADDR_L-1.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of contents.
- `we` input 1: write request, one entry per cycle while high.
- `din` input DATA_L: write data, sampled when `we` is high.
- `re` input 1: read request, one entry per cycle while high.
- `dout` output DATA_L: read data.
- `w_ack` output 1: one-cycle pulse, write accepted.
- `r_ack` output 1: one-cycle pulse, read accepted and `dout` valid.
- `count` output ADDR_L+1: current occupancy, 0..2^ADDR_L.
- `full`, `avail` output 1: count == depth; count != 0.
- `almost_full` output 1: see AFULL_TH.
- `ovf_err`, `udf_err` output 1: sticky write-when-full / read-when-empty.

## Operation
- Storage: `2^ADDR_L x DATA_L` array.
- Pointers: `rpt` and `wpt` are ADDR_L bits wide and wrap naturally modulo depth.
- Count register: ADDR_L+1 bits, the sole source of `full`, `avail` and `almost_full`.
- Write accepted when `we && (!full || re_accepted)`:
  - stores `din` at `wpt`;
  - `wpt+1`;
  - `w_ack`=1 next cycle.
- Write rejected when `we && full && !re`:
  - no state change;
  - `ovf_err`<=1;
  - `w_ack`=0;
  - `$display` "BUF:ID:%d ERROR FULL".
- Read accepted when `re && avail`:
  - `dout`<=data[rpt];
  - `rpt+1`;
  - `r_ack`=1.
- Read rejected when `re && !avail`:
  - `dout` holds its previous value;
  - `udf_err`<=1;
  - `r_ack`=0;
  - `$display` "ERROR EMPTY".
- Simultaneous accepted read and write: count unchanged. This is legal when full; the read frees the slot in the same cycle.
- Read on empty with simultaneous write: the read is rejected (udf) and the write is accepted. There is no bypass.
- `count` update: +1 on write only, -1 on read only, unchanged on both or neither.
- `flush` (synchronous):
  - clears pointers, count, `dout`, the ack outputs and both error flags;
  - wins over `we`/`re` in the same cycle;
  - array contents are not cleared.
- Error flags clear only on `rst` or `flush`.

## Timing
- Reset values: `dout`=0, `w_ack`=0, `r_ack`=0, `count`=0, `ovf_err`=0, `udf_err`=0, `full`=0, `avail`=0, `almost_full`=(AFULL_TH >= depth? never legal, so 0).
- Pointers reset to 0.
- `rst` mid-transfer aborts immediately. Any request active at the reset edge is lost.
- Write-to-read latency: data written at edge N can be read by `re` sampled at edge N+1.
- Read latency (default mode): `dout` and `r_ack` are valid after the edge that samples `re`. `r_ack` lasts one cycle per accepted read.
- `count`, `full`, `avail` and `almost_full` are registered or derived from registered count. They reflect all transfers up to the last edge.
- Back-to-back `we` or `re` sustains one transfer per cycle.

## Configuration
- `BUF_FIFO_FWFT_EN` defined (first-word-fall-through):
  - `dout` continuously shows data[rpt] whenever `avail`=1, and 0 when empty;
  - `re` pops the head;
  - `r_ack` is high in the same cycle as an accepted `re`;
  - a word written at edge N appears on `dout` after edge N.
- Undefined: registered-read behaviour as in Operation/Timing.

## Test plan
- ADDR_L=2, AFULL_TH=1: write 0x11,0x22,0x33,0x44 on consecutive cycles -> `count` 1,2,3,4. `almost_full` rises at count 3. `full`=1 at 4. `w_ack` pulses 4 times.
- Full FIFO, `we` with 0x55 -> `ovf_err`=1, count stays 4. Next, 4 reads -> `dout` 0x11,0x22,0x33,0x44 with `r_ack` each cycle. Then `avail`=0.
- Empty FIFO, `re`=1 -> `udf_err`=1, `r_ack`=0, `dout` unchanged.
- Empty FIFO, `re` and `we` (0xAA) together -> `udf_err`=1, count=1. Next-cycle read returns 0xAA.
- Full FIFO, `re` and `we` (0x66) together -> count stays 4, no `ovf_err`, `dout`=head. Continue 12 cycles to exercise pointer wrap; data order preserved.
- Count=3 with `ovf_err` set: `flush` together with `we` -> next cycle count=0, `ovf_err`=0, write dropped. Assert `rst` mid-burst -> all outputs 0 immediately.
- FWFT build: a single write of 0x77 -> `dout`=0x77 the following cycle without `re`.
